// File: rtl/ex_sequencer_pkg.sv
// Shared opcode, condition-code and FSM definitions for the execute-stage sequencer.
// Optional trap-on-overflow behaviour is selected with EX_TRAP_ON_OVF_EN.
package ex_sequencer_pkg;

   localparam logic [3:0] OP_ADD       = 4'd0;
   localparam logic [3:0] OP_SUB       = 4'd1;
   localparam logic [3:0] OP_MULT      = 4'd2;
   localparam logic [3:0] OP_AND       = 4'd3;
   localparam logic [3:0] OP_OR        = 4'd4;
   localparam logic [3:0] OP_XOR       = 4'd5;
   localparam logic [3:0] OP_NOT       = 4'd6;
   localparam logic [3:0] OP_EQUAL     = 4'd8;
   localparam logic [3:0] OP_NOT_EQUAL = 4'd9;
   localparam logic [3:0] OP_LT        = 4'd10;
   localparam logic [3:0] OP_LTE       = 4'd11;
   localparam logic [3:0] OP_GT        = 4'd12;
   localparam logic [3:0] OP_GTE       = 4'd13;

   localparam int CC_BR  = 0;
   localparam int CC_OVF = 1;
   localparam int CC_UDF = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Arithmetic/logic ops write the register file; compares and undefined codes do not.
   function automatic logic op_writes_reg(input logic [3:0] op);
      return (op <= OP_NOT);
   endfunction

   function automatic logic op_is_addsub(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/ex_sequencer_cycle_counter.sv
// Loadable down-counter that sets how many EXEC cycles an op is held for.
module ex_cycle_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ex_sequencer.sv
// Execute-stage controller: registers operands for an external ALU, captures its result,
// resolves branches and keeps sticky overflow/underflow. EX_TRAP_ON_OVF_EN adds the trap output.
module ex_sequencer
   import ex_sequencer_pkg::*;
#(
   parameter int MULT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_imm,
   input  logic [4:0]  in_rd,
   input  logic        in_is_branch,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic [31:0] alu_out,
   input  logic [3:0]  alu_cc,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        wb_we,
   output logic        br_valid,
   output logic        br_taken,
   output logic [31:0] br_target,
   input  logic        exc_clr,
   output logic        exc_ovf,
   output logic        exc_udf,
`ifdef EX_TRAP_ON_OVF_EN
   output logic        trap,
`endif
   output logic [1:0]  dbg_state_o,
   output logic [3:0]  dbg_cc_o
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // the offering side holds its payload stable until that edge.

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d, tgt_q, tgt_d, data_q, data_d;
   logic [3:0]  op_q, op_d, cc_q, cc_d;
   logic [4:0]  rd_q, rd_d;
   logic        is_br_q, is_br_d, we_q, we_d, brv_q, brv_d;
   logic        ovf_q, ovf_d, udf_q, udf_d, trap_q, trap_d;
   logic        cnt_zero, capture, ovf_set, udf_set;

   ex_cycle_counter #(.W(4)) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     ((state_q == ST_IDLE) && in_valid),
      .load_val_i ((in_op == OP_MULT) ? MULT_LOAD : 4'd0),
      .dec_i      (state_q == ST_EXEC),
      .zero_o     (cnt_zero)
   );

   assign capture = (state_q == ST_EXEC) && cnt_zero;
   assign ovf_set = capture && op_is_addsub(op_q) && alu_cc[CC_OVF];
   assign udf_set = capture && (op_q == OP_SUB) && alu_cc[CC_UDF];

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      rd_d    = rd_q;
      is_br_d = is_br_q;
      tgt_d   = tgt_q;
      data_d  = data_q;
      cc_d    = cc_q;
      we_d    = we_q;
      brv_d   = 1'b0;
      trap_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               op_d    = in_op;
               rd_d    = in_rd;
               is_br_d = in_is_branch;
               tgt_d   = in_pc + in_imm;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (cnt_zero) begin
               data_d  = alu_out;
               cc_d    = alu_cc;
`ifdef EX_TRAP_ON_OVF_EN
               we_d    = op_writes_reg(op_q) && !ovf_set;
               trap_d  = ovf_set;
`else
               we_d    = op_writes_reg(op_q);
`endif
               brv_d   = is_br_q;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (wb_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // A flag being set on the same edge as a clear must survive.
      ovf_d = ovf_set || (ovf_q && !exc_clr);
      udf_d = udf_set || (udf_q && !exc_clr);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         rd_q    <= '0;
         is_br_q <= 1'b0;
         tgt_q   <= '0;
         data_q  <= '0;
         cc_q    <= '0;
         we_q    <= 1'b0;
         brv_q   <= 1'b0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
         trap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         is_br_q <= is_br_d;
         tgt_q   <= tgt_d;
         data_q  <= data_d;
         cc_q    <= cc_d;
         we_q    <= we_d;
         brv_q   <= brv_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
         trap_q  <= trap_d;
      end
   end

   assign in_ready    = rst_n && (state_q == ST_IDLE);
   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign alu_op      = op_q;
   assign wb_valid    = (state_q == ST_RESP);
   assign wb_data     = data_q;
   assign wb_rd       = rd_q;
   assign wb_we       = we_q;
   assign br_valid    = brv_q;
   assign br_taken    = cc_q[CC_BR];
   assign br_target   = tgt_q;
   assign exc_ovf     = ovf_q;
   assign exc_udf     = udf_q;
   assign dbg_state_o = state_q;
   assign dbg_cc_o    = cc_q;
`ifdef EX_TRAP_ON_OVF_EN
   assign trap        = trap_q;
`else
   logic unused_trap;
   assign unused_trap = trap_q;
`endif

endmodule

// File: doc/ex_sequencer.md
Name: ex_sequencer

Overview:
- Execute-stage controller that drives the combinational ALU: accepts a decoded op over a valid/ready handshake and issues registered operands plus alu_op.
- Captures alu_out/alu_cc, resolves branches (target = pc + imm) and maintains sticky overflow/underflow status.
- Presents the result to writeback over a second valid/ready handshake.
- Sits between decode and writeback; the ALU is instantiated outside, beside it.

Parameters:
- MULT_CYCLES, 2, number of EXEC cycles held for MULT; range 1-15. All other ops take 1 EXEC cycle.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  decode offers op
- in_ready  out  1  sequencer can accept
- in_op  in  4  ALU opcode
- in_a  in  32  operand a
- in_b  in  32  operand b
- in_pc  in  32  PC of op
- in_imm  in  32  branch offset
- in_rd  in  5  destination register
- in_is_branch  in  1  op is conditional branch
- alu_a  out  32  registered operand to ALU
- alu_b  out  32  registered operand to ALU
- alu_op  out  4  registered opcode to ALU
- alu_out  in  32  ALU result
- alu_cc  in  4  {rsvd, underflow, overflow, branch_true}
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts
- wb_data  out  32  captured result
- wb_rd  out  5  destination
- wb_we  out  1  register write enable
- br_valid  out  1  one-cycle pulse, branch resolved
- br_taken  out  1  branch outcome, valid with br_valid
- br_target  out  32  in_pc + in_imm, mod 2^32
- exc_clr  in  1  clears sticky flags
- exc_ovf  out  1  sticky overflow
- exc_udf  out  1  sticky underflow (SUB borrow)

Behaviour:
- Opcodes: ADD 0, SUB 1, MULT 2, AND 3, OR 4, XOR 5, NOT 6, EQUAL 8, NOT_EQUAL 9, LESS_THAN 10, LESS_THAN_EQUAL 11, GREATER_THAN 12, GREATER_THAN_EQUAL 13.
- Undefined opcodes (7, 14, 15) execute as a no-op: wb_we=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE: in_ready=1. On in_valid, latch all inputs into alu_a/alu_b/alu_op/pc/imm/rd/is_branch, then go to EXEC.
- EXEC: a down-counter is loaded with MULT_CYCLES-1 for MULT and 0 otherwise. While the counter is nonzero, decrement it. When it is 0, capture alu_out into wb_data and alu_cc into a cc register, then go to RESP.
- RESP: wb_valid=1; wb_data/wb_rd/wb_we stay stable until wb_valid and wb_ready are both high in the same cycle, then go to IDLE. in_ready=0 in EXEC and RESP.
- Minimum latency: accept at edge N, wb_valid high from cycle N+2. Throughput: one op per 3 cycles at best.
- wb_we: 1 for ops 0-6, 0 for compares (8-13). Compares still put alu_out (0) on wb_data.
- Branch: br_valid pulses for exactly the first RESP cycle when is_branch=1. br_taken = captured cc[0]. br_target is computed at accept time.
- Sticky flags:
  - exc_ovf is set on the capture edge if the op is ADD or SUB and cc[1]=1.
  - exc_udf is set on the capture edge if the op is SUB and cc[2]=1.
  - exc_clr clears both; if a set and exc_clr occur on the same edge, the set wins.
- Reset values: in_ready=0 during reset then 1; every other output 0; state=IDLE; counter=0; sticky flags 0.
- Reset mid-operation: the op in flight is discarded and br_valid is not emitted.
- Operands are frozen from accept until the next accept; changes on in_* outside IDLE are ignored.

Optional Feature:
- Macro: EX_TRAP_ON_OVF_EN.
- Defined: adds output trap (1 bit). If the capture sets overflow on ADD/SUB, wb_we is forced to 0 and trap pulses for the first RESP cycle; the sticky flag is still set.
- Undefined: no trap port; overflowed results write back normally, and only the sticky flag records the overflow.

Decomposition:
- Shared package/defines holds:
  - the 4-bit opcode constants above;
  - the alu_cc bit indices CC_BR=0, CC_OVF=1, CC_UDF=2;
  - the FSM state encoding (IDLE=0, EXEC=1, RESP=2).
- Sub-module ex_cycle_counter (load value, decrement, zero flag) is natural. The FSM and datapath registers stay in ex_sequencer.

Test Plan:
- ADD 0x7FFFFFFF + 1 with wb_ready=1 -> wb_valid at N+2, wb_data=0x80000000, wb_we=1, exc_ovf=1 afterwards. With EX_TRAP_ON_OVF_EN: wb_we=0 and trap pulses.
- SUB 0 - 1 -> wb_data=0xFFFFFFFF, exc_udf=1, exc_ovf=0. Then exc_clr on the capture edge of a second overflowing ADD -> exc_ovf stays 1.
- MULT 3 * 5 with MULT_CYCLES=4 -> wb_valid at N+5, wb_data=15. in_ready stays 0 throughout and in_valid is ignored.
- LESS_THAN branch, a=-2, b=1, pc=0x100, imm=0x20 -> br_valid one cycle, br_taken=1, br_target=0x120, wb_we=0. With a=5: br_taken=0.
- wb_ready held low 4 cycles in RESP -> wb_valid, wb_data and wb_rd stable, br_valid pulses only once, in_ready=0; the handshake completes on the first cycle wb_ready=1.
- rst_n low during EXEC of a MULT -> next cycle all outputs 0 and state IDLE; after release, no stale wb_valid or br_valid.
